batch_sorter: RTL and testbench

//  Parametrised batch sorter: accepts a batch of up to DEPTH samples, then emits them one per

---
 rtl/sort_pkg.sv | 15 +
 rtl/batch_sorter_if.sv | 35 +++
 rtl/sort_cmp_node.sv | 45 ++++
 rtl/batch_sorter.sv | 128 ++++++++++++
 tb/tb_batch_sorter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared types and defaults for the batch sorter
// Purpose: FSM state encoding and default geometry used by batch_sorter and its interface.
// Ports: none (package).
package sort_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } sort_state_t;

    localparam int SORT_DATA_W_DEF = 16;
    localparam int SORT_DEPTH_DEF  = 16;

endpackage

// File: rtl/batch_sorter_if.sv
// rtl/batch_sorter_if.sv - sample-in / ranked-value-out handshake bundle
// Purpose: groups the producer-side and consumer-side handshakes of batch_sorter.
// Ports (signals): sob, in_vld, in_last, din, mode_asc -> sorter; in_rdy <- sorter;
//                  dout, out_idx, out_vld, out_last <- sorter; out_rdy -> sorter.
// Modports: master = producer/consumer side, slave = sorter side.
interface batch_sorter_if
    import sort_pkg::*;
#(
    parameter int DATA_W = SORT_DATA_W_DEF,
    parameter int DEPTH  = SORT_DEPTH_DEF
);
    localparam int IDX_W = $clog2(DEPTH);

    logic              sob;
    logic              in_vld;
    logic              in_last;
    logic [DATA_W-1:0] din;
    logic              mode_asc;
    logic              in_rdy;
    logic [DATA_W-1:0] dout;
    logic [IDX_W-1:0]  out_idx;
    logic              out_vld;
    logic              out_rdy;
    logic              out_last;

    modport master (
        output sob, in_vld, in_last, din, mode_asc, out_rdy,
        input  in_rdy, dout, out_idx, out_vld, out_last
    );

    modport slave (
        input  sob, in_vld, in_last, din, mode_asc, out_rdy,
        output in_rdy, dout, out_idx, out_vld, out_last
    );
endinterface

// File: rtl/sort_cmp_node.sv
// rtl/sort_cmp_node.sv - one comparator node of the winner-selection tree
// Purpose: picks the winning (vld, d, idx) tuple of two candidates.
// Ports: a_*_i, b_*_i candidate tuples; asc_i order select (1 = min wins);
//        w_*_o winning tuple.
module sort_cmp_node #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4,
    parameter bit SIGNED = 1'b1
) (
    input  logic              a_vld_i,
    input  logic [DATA_W-1:0] a_d_i,
    input  logic [IDX_W-1:0]  a_idx_i,
    input  logic              b_vld_i,
    input  logic [DATA_W-1:0] b_d_i,
    input  logic [IDX_W-1:0]  b_idx_i,
    input  logic              asc_i,
    output logic              w_vld_o,
    output logic [DATA_W-1:0] w_d_o,
    output logic [IDX_W-1:0]  w_idx_o
);
    logic a_gt_b;
    logic a_lt_b;
    logic a_beats_b;
    logic a_wins;

    generate
        if (SIGNED) begin : g_signed
            assign a_gt_b = $signed(a_d_i) > $signed(b_d_i);
            assign a_lt_b = $signed(a_d_i) < $signed(b_d_i);
        end else begin : g_unsigned
            assign a_gt_b = a_d_i > b_d_i;
            assign a_lt_b = a_d_i < b_d_i;
        end
    endgenerate

    assign a_beats_b = asc_i ? a_lt_b : a_gt_b;

    // Ties resolve to the lower arrival index so equal values leave in arrival order.
    assign a_wins = a_vld_i & (~b_vld_i | a_beats_b |
                               ((a_d_i == b_d_i) & (a_idx_i < b_idx_i)));

    assign w_vld_o = a_wins ? a_vld_i : b_vld_i;
    assign w_d_o   = a_wins ? a_d_i   : b_d_i;
    assign w_idx_o = a_wins ? a_idx_i : b_idx_i;
endmodule

// File: rtl/batch_sorter.sv
// rtl/batch_sorter.sv - buffered batch sorter with comparator-tree drain
// Purpose: collects up to DEPTH samples per batch, then emits them one per handshake in
//          ascending or descending order with their arrival index.
// Ports: clk, rstn (async, active-low); bus (slave modport of batch_sorter_if) carrying the
//        input stream (sob/in_vld/in_last/din/mode_asc/in_rdy) and the ranked output
//        (dout/out_idx/out_vld/out_rdy/out_last).
module batch_sorter
    import sort_pkg::*;
#(
    parameter int DATA_W = SORT_DATA_W_DEF,
    parameter int DEPTH  = SORT_DEPTH_DEF,
    parameter bit SIGNED = 1'b1
) (
    input  logic           clk,
    input  logic           rstn,
    batch_sorter_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LVLS  = IDX_W;

    sort_state_t       state_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [IDX_W-1:0]  wr_cnt_q;
    logic              asc_q;

    logic              in_rdy;
    logic              accept;
    logic              one_left;
    logic              win_vld;
    logic [DATA_W-1:0] win_d;
    logic [IDX_W-1:0]  win_idx;

    // Winner tree, one generate block per level; level LVLS holds the leaves, level 0 the root.
    generate
        for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
            logic [(1<<l)-1:0]             vld;
            logic [(1<<l)-1:0][DATA_W-1:0] d;
            logic [(1<<l)-1:0][IDX_W-1:0]  idx;

            if (l == LVLS) begin : g_leaf
                for (genvar k = 0; k < DEPTH; k++) begin : g_ent
                    assign vld[k] = vld_q[k];
                    assign d[k]   = mem_q[k];
                    assign idx[k] = IDX_W'(k);
                end
            end else begin : g_cmp
                for (genvar n = 0; n < (1 << l); n++) begin : g_node
                    sort_cmp_node #(
                        .DATA_W (DATA_W),
                        .IDX_W  (IDX_W),
                        .SIGNED (SIGNED)
                    ) u_node (
                        .a_vld_i (g_lvl[l+1].vld[2*n]),
                        .a_d_i   (g_lvl[l+1].d[2*n]),
                        .a_idx_i (g_lvl[l+1].idx[2*n]),
                        .b_vld_i (g_lvl[l+1].vld[2*n+1]),
                        .b_d_i   (g_lvl[l+1].d[2*n+1]),
                        .b_idx_i (g_lvl[l+1].idx[2*n+1]),
                        .asc_i   (asc_q),
                        .w_vld_o (vld[n]),
                        .w_d_o   (d[n]),
                        .w_idx_o (idx[n])
                    );
                end
            end
        end
    endgenerate

    assign win_vld = g_lvl[0].vld[0];
    assign win_d   = g_lvl[0].d[0];
    assign win_idx = g_lvl[0].idx[0];

    assign in_rdy   = (state_q != S_DRAIN);
    assign accept   = bus.in_vld & in_rdy;
    // Exactly one valid entry left: nonzero and a power of two.
    assign one_left = (vld_q != '0) && ((vld_q & (vld_q - 1'b1)) == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            vld_q    <= '0;
            wr_cnt_q <= '0;
            asc_q    <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE, S_LOAD: begin
                    if (accept) begin
                        if (bus.sob) begin
                            // Start (or restart after abort): discard any partial batch.
                            mem_q[0] <= bus.din;
                            vld_q    <= {{(DEPTH-1){1'b0}}, 1'b1};
                            wr_cnt_q <= IDX_W'(1);
                            asc_q    <= bus.mode_asc;
                            state_q  <= bus.in_last ? S_DRAIN : S_LOAD;
                        end else if (state_q == S_LOAD) begin
                            mem_q[wr_cnt_q] <= bus.din;
                            vld_q[wr_cnt_q] <= 1'b1;
                            wr_cnt_q        <= wr_cnt_q + 1'b1;
                            if (bus.in_last || (wr_cnt_q == IDX_W'(DEPTH - 1))) begin
                                state_q <= S_DRAIN;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.out_rdy) begin
                        vld_q[win_idx] <= 1'b0;
                        if (one_left) begin
                            wr_cnt_q <= '0;
                            state_q  <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_rdy   = in_rdy;
    assign bus.out_vld  = (state_q == S_DRAIN);
    assign bus.out_last = (state_q == S_DRAIN) & one_left;
    assign bus.dout     = ((state_q == S_DRAIN) && win_vld) ? win_d : '0;
    assign bus.out_idx  = ((state_q == S_DRAIN) && win_vld) ? win_idx : '0;
endmodule

// File: tb/tb_batch_sorter.sv
// tb/tb_batch_sorter.sv - self-checking bench for batch_sorter (signed and unsigned instances)
module tb_batch_sorter;
    localparam int DW = 16;
    localparam int DP = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          sob = 1'b0;
    logic          in_vld = 1'b0;
    logic          in_last = 1'b0;
    logic          mode_asc = 1'b0;
    logic          out_rdy = 1'b1;
    logic [DW-1:0] din = '0;

    int tests_run = 0;
    int failed = 0;

    logic [DW-1:0] exp_sd[$];
    int            exp_si[$];
    logic [DW-1:0] exp_ud[$];
    int            exp_ui[$];

    always #5 clk = ~clk;

    batch_sorter_if #(.DATA_W(DW), .DEPTH(DP)) if_s ();
    batch_sorter_if #(.DATA_W(DW), .DEPTH(DP)) if_u ();

    assign if_s.sob = sob;       assign if_u.sob = sob;
    assign if_s.in_vld = in_vld; assign if_u.in_vld = in_vld;
    assign if_s.in_last = in_last; assign if_u.in_last = in_last;
    assign if_s.din = din;       assign if_u.din = din;
    assign if_s.mode_asc = mode_asc; assign if_u.mode_asc = mode_asc;
    assign if_s.out_rdy = out_rdy; assign if_u.out_rdy = out_rdy;

    batch_sorter #(.DATA_W(DW), .DEPTH(DP), .SIGNED(1'b1)) u_dut_s (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if_s)
    );

    batch_sorter #(.DATA_W(DW), .DEPTH(DP), .SIGNED(1'b0)) u_dut_u (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if_u)
    );

    function automatic int key_of(input logic [DW-1:0] v, input bit s);
        if (s) return int'($signed(v));
        return int'({16'h0000, v});
    endfunction

    // Reference: stable selection sort of the batch, for both compare flavours.
    task automatic build_expect(input logic [DW-1:0] v[$], input bit asc);
        exp_sd.delete(); exp_si.delete(); exp_ud.delete(); exp_ui.delete();
        for (int s = 0; s < 2; s++) begin
            bit used [DP];
            foreach (used[j]) used[j] = 1'b0;
            for (int r = 0; r < v.size(); r++) begin
                int best = -1;
                for (int j = 0; j < v.size(); j++) begin
                    if (!used[j]) begin
                        if (best < 0) best = j;
                        else if (asc ? (key_of(v[j], s[0]) < key_of(v[best], s[0]))
                                     : (key_of(v[j], s[0]) > key_of(v[best], s[0]))) best = j;
                    end
                end
                used[best] = 1'b1;
                if (s == 1) begin exp_sd.push_back(v[best]); exp_si.push_back(best); end
                else        begin exp_ud.push_back(v[best]); exp_ui.push_back(best); end
            end
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input bit s, input bit l, input bit asc);
        sob = s; in_vld = 1'b1; din = d; in_last = l; mode_asc = asc;
        @(negedge clk);
        tests_run++;
        if (if_s.in_rdy !== 1'b1 || if_u.in_rdy !== 1'b1) begin
            failed++;
            $display("FAIL in_rdy_load: s=%b u=%b expected 1", if_s.in_rdy, if_u.in_rdy);
        end
        @(posedge clk); #1;
        in_vld = 1'b0; sob = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_batch(input logic [DW-1:0] v[$], input bit asc, input bit mark_last);
        for (int i = 0; i < v.size(); i++)
            send_beat(v[i], i == 0, mark_last && (i == v.size() - 1), asc);
    endtask

    // pat: 0 = always ready, 1 = ready 1,0,0 repeating, 2 = random. Stops after 'stop' takes.
    task automatic drain(input int L, input int pat, input int stop, output int busy);
        int k = 0;
        int cyc = 0;
        bit holding = 1'b0;
        bit rdy;
        logic [DW-1:0] hs, hu;
        logic [IW-1:0] his, hiu;
        busy = 0;
        while (k < stop && cyc < 300) begin
            case (pat)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_rdy = rdy;
            @(negedge clk);
            if (!if_s.in_rdy) busy++;
            tests_run++;
            if (if_s.out_vld !== 1'b1 || if_u.out_vld !== 1'b1) begin
                failed++;
                $display("FAIL drain_out_vld: s=%b u=%b expected 1 at element %0d", if_s.out_vld, if_u.out_vld, k);
            end else begin
                if (holding) begin
                    tests_run++;
                    if (if_s.dout !== hs || if_s.out_idx !== his || if_u.dout !== hu || if_u.out_idx !== hiu) begin
                        failed++;
                        $display("FAIL hold_stable: s=%h/%0d u=%h/%0d expected s=%h/%0d u=%h/%0d",
                                 if_s.dout, if_s.out_idx, if_u.dout, if_u.out_idx, hs, his, hu, hiu);
                    end
                end
                if (rdy) begin
                    tests_run++;
                    if (if_s.dout !== exp_sd[k] || if_s.out_idx !== IW'(exp_si[k]) || if_s.out_last !== (k == L - 1)) begin
                        failed++;
                        $display("FAIL order_signed[%0d]: got %h idx %0d last %b expected %h idx %0d last %b",
                                 k, if_s.dout, if_s.out_idx, if_s.out_last, exp_sd[k], exp_si[k], k == L - 1);
                    end
                    tests_run++;
                    if (if_u.dout !== exp_ud[k] || if_u.out_idx !== IW'(exp_ui[k]) || if_u.out_last !== (k == L - 1)) begin
                        failed++;
                        $display("FAIL order_unsigned[%0d]: got %h idx %0d last %b expected %h idx %0d last %b",
                                 k, if_u.dout, if_u.out_idx, if_u.out_last, exp_ud[k], exp_ui[k], k == L - 1);
                    end
                    k++;
                    holding = 1'b0;
                end else begin
                    holding = 1'b1;
                    hs = if_s.dout; hu = if_u.dout; his = if_s.out_idx; hiu = if_u.out_idx;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_rdy = 1'b1;
        tests_run++;
        if (k < stop) begin
            failed++;
            $display("FAIL drain_timeout: took %0d elements expected %0d", k, stop);
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        tests_run++;
        if (if_s.in_rdy !== 1'b1 || if_s.out_vld !== 1'b0 || if_s.out_last !== 1'b0 ||
            if_s.dout !== '0 || if_s.out_idx !== '0 ||
            if_u.in_rdy !== 1'b1 || if_u.out_vld !== 1'b0 || if_u.out_last !== 1'b0 ||
            if_u.dout !== '0 || if_u.out_idx !== '0) begin
            failed++;
            $display("FAIL %s: s rdy/vld/last/d/idx=%b%b%b/%h/%0d u=%b%b%b/%h/%0d expected 100/0000/0",
                     name, if_s.in_rdy, if_s.out_vld, if_s.out_last, if_s.dout, if_s.out_idx,
                     if_u.in_rdy, if_u.out_vld, if_u.out_last, if_u.dout, if_u.out_idx);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_state");
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_desc();
        logic [DW-1:0] v[$];
        int busy;
        v = '{16'hFFFF, 16'hFFF0, 16'h0000, 16'h1234, 16'h6264, 16'hF264, 16'h5261, 16'h5000,
              16'h2001, 16'hAAAA, 16'h5555, 16'h1111, 16'h2222, 16'h8888, 16'h9999, 16'h1101};
        send_batch(v, 1'b0, 1'b0);      // 16th beat ends the batch without in_last
        build_expect(v, 1'b0);
        drain(16, 0, 16, busy);
        check_idle("full_idle");
    endtask

    task automatic test_short_asc();
        logic [DW-1:0] v[$];
        int busy;
        v = '{16'd5, 16'd3, 16'd7, 16'd3};
        send_batch(v, 1'b1, 1'b1);
        build_expect(v, 1'b1);
        drain(4, 0, 4, busy);
        tests_run++;
        if (busy != 4) begin
            failed++;
            $display("FAIL short_busy: in_rdy low %0d cycles expected 4", busy);
        end
        check_idle("short_idle");
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] v[$];
        int busy;
        for (int i = 0; i < 12; i++) v.push_back(DW'($urandom_range(0, 15)));
        send_batch(v, 1'b0, 1'b1);
        build_expect(v, 1'b0);
        drain(12, 1, 12, busy);
        check_idle("bp_idle");
    endtask

    task automatic test_sign();
        logic [DW-1:0] v[$];
        int busy;
        v = '{16'h8000, 16'h7FFF, 16'h0001};
        send_batch(v, 1'b0, 1'b1);
        build_expect(v, 1'b0);
        drain(3, 0, 3, busy);
        check_idle("sign_idle");
    endtask

    task automatic test_abort();
        logic [DW-1:0] v[$];
        int busy;
        send_beat(16'd10, 1'b1, 1'b0, 1'b0);
        send_beat(16'd20, 1'b0, 1'b0, 1'b0);
        send_beat(16'd1,  1'b1, 1'b1, 1'b0);
        v = '{16'd1};
        build_expect(v, 1'b0);
        drain(1, 0, 1, busy);
        check_idle("abort_idle");
    endtask

    task automatic test_idle_drop();
        logic [DW-1:0] v[$];
        int busy;
        send_beat(16'h7777, 1'b0, 1'b0, 1'b0);
        send_beat(16'h7778, 1'b0, 1'b1, 1'b0);
        check_idle("drop_idle");
        v = '{16'h0010, 16'h0030, 16'h0020};
        send_batch(v, 1'b0, 1'b1);
        build_expect(v, 1'b0);
        drain(3, 0, 3, busy);
        check_idle("drop_after_idle");
    endtask

    task automatic test_reset_mid_drain();
        logic [DW-1:0] v[$];
        logic [DW-1:0] w[$];
        int busy;
        for (int i = 0; i < 8; i++) v.push_back(DW'($urandom));
        send_batch(v, 1'b0, 1'b1);
        build_expect(v, 1'b0);
        drain(8, 0, 2, busy);
        rstn = 1'b0;
        check_idle("mid_drain_reset");
        rstn = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) w.push_back(DW'($urandom));
        send_batch(w, 1'b1, 1'b1);
        build_expect(w, 1'b1);
        drain(6, 0, 6, busy);
        check_idle("post_reset_idle");
    endtask

    task automatic test_random();
        for (int b = 0; b < 20; b++) begin
            logic [DW-1:0] v[$];
            int L;
            int busy;
            bit asc;
            bit narrow;
            bit mark;
            L = $urandom_range(1, DP);
            asc = 1'($urandom_range(0, 1));
            narrow = 1'($urandom_range(0, 1));
            mark = (L < DP) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < L; i++)
                v.push_back(narrow ? DW'($urandom_range(0, 3)) | 16'h8000 * DW'($urandom_range(0, 1)) : DW'($urandom));
            send_batch(v, asc, mark);
            build_expect(v, asc);
            drain(L, 2, L, busy);
            check_idle("random_idle");
        end
    endtask

    initial begin
        test_reset();
        test_full_desc();
        test_short_asc();
        test_backpressure();
        test_sign();
        test_abort();
        test_idle_drop();
        test_reset_mid_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
